// File: rtl/i2c_bus_monitor.sv
// I2C bus monitor: synchronizes SCL/SDA, detects START/STOP and edges, and issues byte-frame strobes.
// Optional per-line glitch filter enabled by defining I2C_GLITCH_FILTER_EN.
module i2c_bus_monitor #(
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic clk,
    input  logic n_rst,
    input  logic scl_raw,
    input  logic sda_raw,
    output logic sda_in,
    output logic start_found,
    output logic stop_found,
    output logic rx_sample,
    output logic tx_shift,
    output logic byte_received,
    output logic ack_prep,
    output logic check_ack,
    output logic ack_done
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_ACK} state_t;

    if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_bad_filter_len
        $error("FILTER_LEN must be within 2..15");
    end

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_f, sda_f;
    logic       scl_q, sda_q;
    logic       rise_q, fall_q, start_q, stop_q;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic start_found_q, stop_found_q, rx_sample_q, tx_shift_q;
    logic byte_received_q, ack_prep_q, check_ack_q, ack_done_q;
    logic start_found_d, stop_found_d, rx_sample_d, tx_shift_d;
    logic byte_received_d, ack_prep_d, check_ack_d, ack_done_d;

    // Two-flop synchronizers, idle-high
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_raw};
            sda_sync_q <= {sda_sync_q[0], sda_raw};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             scl_f_q, sda_f_q;
    logic [CNT_W-1:0] scl_cnt_q, sda_cnt_q;

    // Filtered level follows only after FILTER_LEN consecutive differing samples
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_f_q   <= 1'b1;
            sda_f_q   <= 1'b1;
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
        end else begin
            if (scl_sync_q[1] == scl_f_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == FILT_LAST) begin
                scl_f_q   <= scl_sync_q[1];
                scl_cnt_q <= '0;
            end else begin
                scl_cnt_q <= scl_cnt_q + CNT_W'(1);
            end
            if (sda_sync_q[1] == sda_f_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == FILT_LAST) begin
                sda_f_q   <= sda_sync_q[1];
                sda_cnt_q <= '0;
            end else begin
                sda_cnt_q <= sda_cnt_q + CNT_W'(1);
            end
        end
    end

    assign scl_f = scl_f_q;
    assign sda_f = sda_f_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Previous-value registers and registered edge/condition terms
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_q   <= 1'b1;
            sda_q   <= 1'b1;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            scl_q   <= scl_f;
            sda_q   <= sda_f;
            rise_q  <= scl_f & ~scl_q;
            fall_q  <= ~scl_f & scl_q;
            start_q <= sda_q & ~sda_f & scl_f & scl_q;
            stop_q  <= ~sda_q & sda_f & scl_f & scl_q;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= ST_IDLE;
            bit_cnt_q       <= '0;
            start_found_q   <= 1'b0;
            stop_found_q    <= 1'b0;
            rx_sample_q     <= 1'b0;
            tx_shift_q      <= 1'b0;
            byte_received_q <= 1'b0;
            ack_prep_q      <= 1'b0;
            check_ack_q     <= 1'b0;
            ack_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            bit_cnt_q       <= bit_cnt_d;
            start_found_q   <= start_found_d;
            stop_found_q    <= stop_found_d;
            rx_sample_q     <= rx_sample_d;
            tx_shift_q      <= tx_shift_d;
            byte_received_q <= byte_received_d;
            ack_prep_q      <= ack_prep_d;
            check_ack_q     <= check_ack_d;
            ack_done_q      <= ack_done_d;
        end
    end

    // Frame sequencing; STOP/START override any SCL edge
    always_comb begin
        state_d         = state_q;
        bit_cnt_d       = bit_cnt_q;
        start_found_d   = 1'b0;
        stop_found_d    = 1'b0;
        rx_sample_d     = 1'b0;
        tx_shift_d      = 1'b0;
        ack_prep_d      = 1'b0;
        check_ack_d     = 1'b0;
        ack_done_d      = 1'b0;
        byte_received_d = rx_sample_q && (bit_cnt_q == CNT_W'(8));

        if (stop_q) begin
            state_d      = ST_IDLE;
            bit_cnt_d    = '0;
            stop_found_d = 1'b1;
        end else if (start_q) begin
            state_d       = ST_DATA;
            bit_cnt_d     = '0;
            start_found_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: ;
                ST_DATA: begin
                    if (rise_q && (bit_cnt_q < CNT_W'(8))) begin
                        rx_sample_d = 1'b1;
                        bit_cnt_d   = bit_cnt_q + CNT_W'(1);
                    end else if (fall_q) begin
                        if (bit_cnt_q == CNT_W'(8)) begin
                            ack_prep_d = 1'b1;
                            state_d    = ST_ACK;
                        end else if (bit_cnt_q != '0) begin
                            tx_shift_d = 1'b1;
                        end
                    end
                end
                ST_ACK: begin
                    if (rise_q) begin
                        check_ack_d = 1'b1;
                    end else if (fall_q) begin
                        ack_done_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign sda_in        = sda_q;
    assign start_found   = start_found_q;
    assign stop_found    = stop_found_q;
    assign rx_sample     = rx_sample_q;
    assign tx_shift      = tx_shift_q;
    assign byte_received = byte_received_q;
    assign ack_prep      = ack_prep_q;
    assign check_ack     = check_ack_q;
    assign ack_done      = ack_done_q;
endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Scoreboard bench for i2c_bus_monitor: bus stimulus pushes expected strobes, a monitor pops and compares.
module tb_i2c_bus_monitor;
    localparam int unsigned FLEN = 3;
`ifdef I2C_GLITCH_FILTER_EN
    localparam int unsigned LAT = 3 + FLEN;
`else
    localparam int unsigned LAT = 3;
`endif

    localparam logic [7:0] EV_START = 8'h10;
    localparam logic [7:0] EV_STOP  = 8'h20;
    localparam logic [7:0] EV_RX    = 8'h30;
    localparam logic [7:0] EV_TX    = 8'h40;
    localparam logic [7:0] EV_BYTE  = 8'h50;
    localparam logic [7:0] EV_ACKP  = 8'h60;
    localparam logic [7:0] EV_CHK   = 8'h70;
    localparam logic [7:0] EV_ACKD  = 8'h80;

    logic clk = 1'b0;
    logic n_rst, scl_raw, sda_raw;
    logic sda_in, start_found, stop_found, rx_sample, tx_shift;
    logic byte_received, ack_prep, check_ack, ack_done;
    logic [7:0] pulses;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rise_cyc = 0;
    int last_rx_cyc = 0;
    logic [7:0] exp_q[$];
    int byte_cyc[$];

    i2c_bus_monitor #(.FILTER_LEN(FLEN)) dut (
        .clk(clk), .n_rst(n_rst), .scl_raw(scl_raw), .sda_raw(sda_raw),
        .sda_in(sda_in), .start_found(start_found), .stop_found(stop_found),
        .rx_sample(rx_sample), .tx_shift(tx_shift), .byte_received(byte_received),
        .ack_prep(ack_prep), .check_ack(check_ack), .ack_done(ack_done)
    );

    assign pulses = {start_found, stop_found, rx_sample, tx_shift,
                     byte_received, ack_prep, check_ack, ack_done};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic observe(input logic [7:0] code);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check("unexpected_pulse", 32'(code), 32'h0);
        end else begin
            e = exp_q.pop_front();
            check("event", 32'(code), 32'(e));
        end
    endtask

    // Monitor: sample strobes on the falling clock edge
    always @(negedge clk) begin
        if (n_rst === 1'b1) begin
            if (start_found)   observe(EV_START);
            if (stop_found)    observe(EV_STOP);
            if (rx_sample) begin
                last_rx_cyc = cyc;
                observe(EV_RX | {7'b0, sda_in});
            end
            if (tx_shift)      observe(EV_TX);
            if (byte_received) begin
                byte_cyc.push_back(cyc);
                observe(EV_BYTE);
            end
            if (ack_prep)      observe(EV_ACKP);
            if (check_ack)     observe(EV_CHK);
            if (ack_done)      observe(EV_ACKD);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_start();
        exp_q.push_back(EV_START);
        scl_raw = 1'b1;
        sda_raw = 1'b0;
        wait_cyc(5);
        scl_raw = 1'b0;
        wait_cyc(3);
    endtask

    task automatic send_bit(input logic b, input int idx);
        exp_q.push_back(EV_RX | {7'b0, b});
        if (idx < 8) exp_q.push_back(EV_TX);
        else begin
            exp_q.push_back(EV_BYTE);
            exp_q.push_back(EV_ACKP);
        end
        sda_raw = b;
        wait_cyc(2);
        rise_cyc = cyc;
        scl_raw = 1'b1;
        wait_cyc(5);
        scl_raw = 1'b0;
        wait_cyc(3);
        check("rise_to_rx_latency", 32'(last_rx_cyc - rise_cyc - 1), 32'(LAT));
    endtask

    task automatic send_byte(input logic [7:0] d);
        for (int i = 7; i >= 0; i--) send_bit(d[i], 8 - i);
    endtask

    task automatic send_ack();
        exp_q.push_back(EV_CHK);
        exp_q.push_back(EV_ACKD);
        sda_raw = 1'b0;
        wait_cyc(2);
        scl_raw = 1'b1;
        wait_cyc(5);
        scl_raw = 1'b0;
        wait_cyc(3);
    endtask

    // STOP from SCL low: the SCL rise is seen as a data sample of the low SDA level
    task automatic do_stop();
        exp_q.push_back(EV_RX);
        exp_q.push_back(EV_STOP);
        sda_raw = 1'b0;
        wait_cyc(2);
        scl_raw = 1'b1;
        wait_cyc(3);
        sda_raw = 1'b1;
        wait_cyc(8);
    endtask

    task automatic scl_clocks(input int n);
        for (int i = 0; i < n; i++) begin
            scl_raw = 1'b0;
            wait_cyc(5);
            scl_raw = 1'b1;
            wait_cyc(5);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d expected events pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst   = 1'b0;
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        wait_cyc(3);
        check("reset_pulses", 32'(pulses), 32'h0);
        check("reset_sda_in", 32'(sda_in), 32'h1);
        n_rst = 1'b1;
        wait_cyc(20);
        check("idle_pulses", 32'(pulses), 32'h0);
        check("idle_sda_in", 32'(sda_in), 32'h1);

        // Single byte 0xA5 with ACK
        do_start();
        send_byte(8'hA5);
        send_ack();
        wait_cyc(10);
        check("byte_a5_pending", 32'(exp_q.size()), 32'h0);

        // Two back-to-back bytes then STOP
        byte_cyc.delete();
        send_byte(8'h3C);
        send_ack();
        send_byte(8'hC3);
        send_ack();
        do_stop();
        check("b2b_byte_count", 32'(byte_cyc.size()), 32'd2);
        if (byte_cyc.size() == 2)
            check("b2b_byte_spacing", 32'(byte_cyc[1] - byte_cyc[0]), 32'd90);
        scl_clocks(3);
        wait_cyc(10);
        check("after_stop_pending", 32'(exp_q.size()), 32'h0);

        // Repeated START after bit 4, then a full byte
        do_start();
        send_bit(1'b1, 1);
        send_bit(1'b0, 2);
        send_bit(1'b1, 3);
        send_bit(1'b1, 4);
        exp_q.push_back(EV_RX | 8'h01);
        exp_q.push_back(EV_START);
        sda_raw = 1'b1;
        wait_cyc(2);
        scl_raw = 1'b1;
        wait_cyc(2);
        sda_raw = 1'b0;
        wait_cyc(3);
        scl_raw = 1'b0;
        wait_cyc(3);
        send_byte(8'h96);
        send_ack();
        do_stop();
        wait_cyc(10);
        check("rstart_pending", 32'(exp_q.size()), 32'h0);

        // Reset mid-frame
        do_start();
        send_bit(1'b0, 1);
        send_bit(1'b1, 2);
        send_bit(1'b1, 3);
        wait_cyc(10);
        n_rst = 1'b0;
        wait_cyc(3);
        check("midrst_pulses", 32'(pulses), 32'h0);
        check("midrst_sda_in", 32'(sda_in), 32'h1);
        sda_raw = 1'b1;
        n_rst = 1'b1;
        scl_clocks(3);
        wait_cyc(10);
        check("midrst_pending", 32'(exp_q.size()), 32'h0);
        check("midrst_idle_pulses", 32'(pulses), 32'h0);

`ifdef I2C_GLITCH_FILTER_EN
        // SDA glitches while SCL high: 2 cycles rejected, 3 cycles accepted
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        wait_cyc(10);
        sda_raw = 1'b0;
        wait_cyc(2);
        sda_raw = 1'b1;
        wait_cyc(12);
        check("glitch2_pending", 32'(exp_q.size()), 32'h0);
        exp_q.push_back(EV_START);
        sda_raw = 1'b0;
        wait_cyc(3);
        sda_raw = 1'b1;
        wait_cyc(4);
        exp_q.push_back(EV_STOP);
        wait_cyc(12);
        check("glitch3_pending", 32'(exp_q.size()), 32'h0);
`endif

        wait_cyc(10);
        check("final_pending", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Front end of the I2C slave path, directly upstream of `i2c_controller`. It synchronizes the raw SCL/SDA pins, detects edges and START/STOP conditions, and counts bits within each 9-clock byte frame. It generates the single-cycle strobes the controller sequences on: `start_found`, `stop_found`, `byte_received`, `ack_prep`, `check_ack`, `ack_done`. It also supplies the shift strobes for the RX/TX shift registers.

## Interface
- `FILTER_LEN`, 3: consecutive clk cycles a line must be stable before the filtered value changes. Used only with `I2C_GLITCH_FILTER_EN`; legal range 2..15.

Ports:
- `clk` input 1: system clock.
- `n_rst` input 1: asynchronous, active-low reset.
- `scl_raw` input 1: SCL pin, asynchronous to clk.
- `sda_raw` input 1: SDA pin, asynchronous to clk.
- `sda_in` output 1: synchronized (and filtered) SDA level; feeds controller `sda_in` and the RX shift register.
- `start_found` output 1: 1-cycle pulse on START or repeated START.
- `stop_found` output 1: 1-cycle pulse on STOP.
- `rx_sample` output 1: 1-cycle pulse on each SCL rising edge of data bits 1..8; the RX shift register shifts in `sda_in`.
- `tx_shift` output 1: 1-cycle pulse on SCL falling edges after data bits 1..7; the TX shift register advances.
- `byte_received` output 1: 1-cycle pulse, one cycle after the 8th `rx_sample`.
- `ack_prep` output 1: 1-cycle pulse on the SCL falling edge ending bit 8.
- `check_ack` output 1: 1-cycle pulse on the SCL rising edge of the ACK (9th) bit.
- `ack_done` output 1: 1-cycle pulse on the SCL falling edge ending the ACK bit.

## Operation
- Synchronizer: two flops per line, reset to 1 (idle bus high). Result goes into the optional filter, producing `scl_f`/`sda_f`, then into a previous-value register `scl_q`/`sda_q`, which also resets to 1.
- Edge terms:
  - rise = `scl_f & ~scl_q`; fall = `~scl_f & scl_q`.
  - START = `sda_q & ~sda_f & scl_f & scl_q`.
  - STOP = `~sda_q & sda_f & scl_f & scl_q`.
- FSM states: IDLE, DATA, ACK. Bit counter `bit_cnt` is 4 bits, range 0..8.
  - IDLE: ignores SCL edges. START → DATA, `bit_cnt` = 0.
  - DATA, on rise: pulse `rx_sample`, `bit_cnt`++. If `bit_cnt` becomes 8, pulse `byte_received` in the next cycle.
  - DATA, on fall: if `bit_cnt` is 1..7, pulse `tx_shift`. If `bit_cnt` = 8, pulse `ack_prep` and go to ACK.
  - ACK, on rise: pulse `check_ack`.
  - ACK, on fall: pulse `ack_done`, `bit_cnt` = 0, go to DATA.
- Priority: STOP and START beat SCL edges; they cannot occur in the same cycle as each other. START in any state → DATA with `bit_cnt` = 0 (repeated START). STOP in any state → IDLE with `bit_cnt` = 0.
- A fall while in DATA with `bit_cnt` = 0 produces no pulse. This covers the falling edge that follows START.
- The block is purely observational. It has no outputs to the bus and never drives SDA.

## Timing
- Reset values:
  - All pulse outputs 0; `sda_in` = 1.
  - Synchronizer, filter and previous-value registers all 1.
  - FSM IDLE, `bit_cnt` 0.
  - Reset mid-frame aborts the frame silently, with no pulses.
- All outputs are registered. No combinational path runs from pins to outputs.
- Latency without the filter: a pin transition first sampled at clk edge k produces its pulse at the output from edge k+3, high for exactly 1 cycle. `byte_received` appears at k+4 relative to the 8th SCL rise.
- Latency with the filter: add `FILTER_LEN` cycles.
- SCL high and low phases must each be at least 4 clk cycles (without filter) for every edge to be resolved. Shorter phases are outside spec.
- SDA changing while SCL is high is always read as START or STOP, never as data.

## Configuration
- `I2C_GLITCH_FILTER_EN` defined:
  - Each synchronized line passes a stability filter with a per-line counter.
  - `scl_f`/`sda_f` take the new level only after `FILTER_LEN` consecutive cycles of the differing value.
  - Any return to the current filtered level clears the counter, so glitches shorter than `FILTER_LEN` cycles are removed.
  - Filter outputs reset to 1.
- Not defined: `scl_f`/`sda_f` equal the synchronizer outputs directly, no filter logic is generated, and the `FILTER_LEN` parameter is unused.

## Test plan
- Reset, then hold both pins at 1 for 20 cycles → all pulses stay 0 and `sda_in` = 1. Drop `n_rst` mid-frame → FSM in IDLE, no pulses.
- START, then byte 0xA5 (8 SCL periods of 10 cycles), then ACK clock → exactly 1 `start_found`, 8 `rx_sample` with `sda_in` sampled as 1,0,1,0,0,1,0,1, 7 `tx_shift`, and one pulse each of `byte_received`, `ack_prep`, `check_ack`, `ack_done`, in that order.
- Two back-to-back bytes, then STOP → second `byte_received` exactly 9 SCL periods after the first, then `stop_found`, then FSM IDLE. SCL edges after the STOP → no pulses.
- Repeated START after bit 4 → `start_found`, `bit_cnt` reset, and `byte_received` only after 8 further rises.
- Check the edge-to-pulse delay on an SCL rise → `rx_sample` 3 cycles after first sample without the filter; with `I2C_GLITCH_FILTER_EN` and `FILTER_LEN` = 3, 6 cycles.
- `I2C_GLITCH_FILTER_EN`, `FILTER_LEN` = 3: a 2-cycle SDA low glitch while SCL is high → no `start_found`. A 3-cycle glitch → `start_found`.
